pc_stack_16: RTL and testbench

PC_STACK_16 -- requirements
Module: pc_stack_16

---
 rtl/pc_stack_16.sv | 105 ++++++++++
 tb/tb_pc_stack_16.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_stack_16.sv
// Program counter with a hardware return stack.
// One action is taken per cycle, in priority order:
// clear, return (pop), call (push), jump (load), advance (inc), hold.
module pc_stack_16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       pop,
    input  logic                       push,
    input  logic                       load,
    input  logic                       inc,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] out_q, out_d;
    logic [AW:0]      depth_q, depth_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic [AW:0]      depth_m1;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] out_p1;

    // Occupancy flags decoded straight from the depth counter.
    always_comb begin
        full     = (depth_q == (AW+1)'(DEPTH));
        empty    = (depth_q == '0);
        depth_m1 = depth_q - (AW+1)'(1);
        top_idx  = depth_m1[AW-1:0];
        out_p1   = out_q + WIDTH'(1);
    end

    // Prioritised next-state selection for PC, depth, error flag and stack write.
    always_comb begin
        out_d     = out_q;
        depth_d   = depth_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = depth_q[AW-1:0];
        // Return address is always the pre-edge PC+1, regardless of inc.
        mem_wdata = out_p1;
        if (clr) begin
            out_d = '0;
            err_d = 1'b0;
        end else if (pop) begin
            if (!empty) begin
                out_d   = mem_q[top_idx];
                depth_d = depth_m1;
            end else begin
                err_d = 1'b1;
            end
        end else if (push) begin
            out_d = din;
            if (!full) begin
                mem_we  = 1'b1;
                depth_d = depth_q + (AW+1)'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (load) begin
            out_d = din;
        end else if (inc) begin
            out_d = out_p1;
        end
    end

    // Control state; reset forces PC, depth and error immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack storage is not reset; gating with rst_n drops a push caught by reset.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign out   = out_q;
    assign depth = depth_q;
    assign err   = err_q;

endmodule

// File: tb/tb_pc_stack_16.sv
// Directed bench for pc_stack_16 with hand-computed expected values.
module tb_pc_stack_16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0, pop = 1'b0, push = 1'b0, load = 1'b0, inc = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] out;
    logic [3:0]  depth;
    logic        full, empty, err;

    int n_checks = 0;
    int n_errors = 0;

    pc_stack_16 #(.WIDTH(16), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .pop   (pop),
        .push  (push),
        .load  (load),
        .inc   (inc),
        .din   (din),
        .out   (out),
        .depth (depth),
        .full  (full),
        .empty (empty),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one set of controls across a single rising edge, sample 1ns after it.
    task automatic step(input logic c, input logic p, input logic u, input logic l,
                        input logic i, input logic [15:0] d);
        @(negedge clk);
        clr = c; pop = p; push = u; load = l; inc = i; din = d;
        @(posedge clk);
        #1;
        clr = 0; pop = 0; push = 0; load = 0; inc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_out", 32'(out), 0);
        check("rst_depth", 32'(depth), 0);
        check("rst_err", 32'(err), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // inc x3, then asynchronous reset mid-cycle
        repeat (3) step(0, 0, 0, 0, 1, 16'h0);
        check("inc3_out", 32'(out), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // call / return
        step(0, 0, 0, 1, 0, 16'h0010);
        step(0, 0, 1, 0, 0, 16'h0100);
        check("call_out", 32'(out), 32'h0100);
        check("call_depth", 32'(depth), 1);
        step(0, 1, 0, 0, 0, 16'h0);
        check("ret_out", 32'(out), 32'h0011);
        check("ret_depth", 32'(depth), 0);

        // PC wrap on inc
        step(0, 0, 0, 1, 0, 16'hFFFF);
        step(0, 0, 0, 0, 1, 16'h0);
        check("wrap_out", 32'(out), 0);
        check("wrap_err", 32'(err), 0);

        // Fill the stack: push i stores 0x100+i (first stores 0x0001)
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 16'h0100 + 16'(i));
        check("fill_full", 32'(full), 1);
        check("fill_empty", 32'(empty), 0);
        check("fill_out", 32'(out), 32'h0107);
        step(0, 0, 1, 0, 0, 16'h1234);
        check("ovf_out", 32'(out), 32'h1234);
        check("ovf_depth", 32'(depth), 8);
        check("ovf_err", 32'(err), 1);
        step(1, 0, 0, 0, 0, 16'h0);
        check("clr_out", 32'(out), 0);
        check("clr_err", 32'(err), 0);
        check("clr_depth", 32'(depth), 8);
        step(0, 1, 0, 0, 0, 16'h0);
        check("pop7_out", 32'(out), 32'h0107);
        check("pop7_depth", 32'(depth), 7);
        step(0, 1, 0, 0, 0, 16'h0);
        check("pop6_out", 32'(out), 32'h0106);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 16'h0);
        check("pop1_out", 32'(out), 32'h0101);
        step(0, 1, 0, 0, 0, 16'h0);
        check("pop0_out", 32'(out), 32'h0001);
        check("pop0_empty", 32'(empty), 1);

        // Underflow
        do_reset();
        step(0, 0, 0, 1, 0, 16'h0055);
        step(0, 1, 0, 0, 0, 16'h0);
        check("udf_out", 32'(out), 32'h0055);
        check("udf_depth", 32'(depth), 0);
        check("udf_err", 32'(err), 1);
        step(0, 0, 0, 1, 0, 16'h0077);
        check("sticky_err", 32'(err), 1);
        step(1, 0, 0, 0, 0, 16'h0);
        check("clr_err2", 32'(err), 0);

        // Priority
        step(0, 0, 0, 1, 0, 16'h0020);
        step(0, 0, 1, 0, 1, 16'h0030);  // stores 0x21 even with inc asserted
        step(0, 0, 1, 0, 0, 16'h0040);  // stores 0x31
        check("pri_pre_depth", 32'(depth), 2);
        step(1, 1, 1, 1, 1, 16'h0999);
        check("pri_all_out", 32'(out), 0);
        check("pri_all_depth", 32'(depth), 2);
        step(0, 1, 1, 0, 0, 16'h0099);
        check("pri_pop_out", 32'(out), 32'h0031);
        check("pri_pop_depth", 32'(depth), 1);
        step(0, 1, 0, 1, 1, 16'h0088);
        check("pri_pop2_out", 32'(out), 32'h0021);
        check("pri_pop2_depth", 32'(depth), 0);

        // In-flight push aborted by reset
        step(0, 0, 0, 1, 0, 16'h0042);
        @(negedge clk);
        push = 1'b1; din = 16'h0005;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_out", 32'(out), 0);
        check("abort_depth", 32'(depth), 0);
        push = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1, 16'h0);
        check("resume_out", 32'(out), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog bound
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
